// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: SFP link bring-up sequencer gating PCS reset and laser enable,
// supervising PCS sync with retry counting and a state/retry status byte.
module sfp_link_ctrl #(
  parameter int unsigned sys_clk_freq    = 125000000,
  parameter int unsigned reset_hold_us   = 10,
  parameter int unsigned los_debounce_us = 100,
  parameter int unsigned sync_timeout_ms = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sfp_mod_abs,
  input  logic       sfp_los,
  input  logic       sfp_tx_fault,
  input  logic       pcs_sync,
  output logic       sfp_tx_disable,
  output logic       pcs_reset,
  output logic       link_up,
  output logic [7:0] status
);
  localparam logic [31:0] HOLD = 32'(sys_clk_freq / 1000000 * reset_hold_us);
  localparam logic [31:0] DEB  = 32'(sys_clk_freq / 1000000 * los_debounce_us);
  localparam logic [31:0] TMO  = 32'(sys_clk_freq / 1000 * sync_timeout_ms);

  typedef enum logic [3:0] {
    S_IDLE   = 4'h0,
    S_RESET  = 4'h1,
    S_ENABLE = 4'h2,
    S_SYNC   = 4'h3,
    S_LINK   = 4'h4,
    S_FAULT  = 4'hF
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_meta, r_sync, r_retry;
  logic [31:0] r_cnt;
  logic        w_pll, w_abs, w_los, w_fault;
  logic        w_inc, w_restart, w_off, w_link;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {pll_locked, sfp_mod_abs, sfp_los, sfp_tx_fault};
      r_sync <= r_meta;
    end

  assign {w_pll, w_abs, w_los, w_fault} = r_sync;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_retry        <= '0;
      sfp_tx_disable <= 1'b1;
      pcs_reset      <= 1'b1;
      link_up        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= (w_next != r_state || w_restart) ? '0 : r_cnt + 32'd1;
      r_retry        <= (w_inc && r_retry != 4'hF) ? r_retry + 4'd1 : r_retry;
      sfp_tx_disable <= w_off;
      pcs_reset      <= w_off;
      link_up        <= w_link;
    end

  // Loss of lock or module removal overrides everything; a TX fault overrides the per-state rules.
  always_comb begin
    w_next    = r_state;
    w_inc     = 1'b0;
    w_restart = 1'b0;
    if (!w_pll || w_abs)
      w_next = S_IDLE;
    else if (w_fault && (r_state inside {S_ENABLE, S_SYNC, S_LINK})) begin
      w_next = S_FAULT;
      w_inc  = 1'b1;
    end else
      case (r_state)
        S_IDLE:   w_next = S_RESET;
        S_RESET:  w_next = (r_cnt == HOLD - 32'd1) ? S_ENABLE : S_RESET;
        S_ENABLE: begin
          w_restart = w_los;
          w_next    = (!w_los && r_cnt == DEB - 32'd1) ? S_SYNC : S_ENABLE;
        end
        S_SYNC: begin
          w_inc  = !pcs_sync && r_cnt == TMO - 32'd1;
          w_next = pcs_sync ? S_LINK : w_inc ? S_RESET : S_SYNC;
        end
        S_LINK: begin
          w_inc  = !pcs_sync || w_los;
          w_next = w_inc ? S_RESET : S_LINK;
        end
        S_FAULT: begin
          w_restart = r_cnt == HOLD - 32'd1 && w_fault;
          w_next    = (r_cnt == HOLD - 32'd1 && !w_fault) ? S_IDLE : S_FAULT;
        end
        default:  w_next = S_IDLE;
      endcase
  end

  always_comb begin
    w_off  = w_next inside {S_IDLE, S_RESET, S_FAULT};
    w_link = w_next == S_LINK;
  end

  assign status = {r_state, r_retry};
endmodule

// File: tb/tb_sfp_link_ctrl.sv
// tb_sfp_link_ctrl: directed bring-up/fault scenarios checked against a
// cycle-level behavioural model of the sequencer.
module tb_sfp_link_ctrl;
  localparam int HOLD = 4, DEB = 8, TMO = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pll_locked = 1'b0, sfp_mod_abs = 1'b1, sfp_los = 1'b1, sfp_tx_fault = 1'b0, pcs_sync = 1'b0;
  logic sfp_tx_disable, pcs_reset, link_up;
  logic [7:0] status;
  int errors = 0, checks = 0;

  sfp_link_ctrl #(
    .sys_clk_freq(1000000), .reset_hold_us(4), .los_debounce_us(8), .sync_timeout_ms(1)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .sfp_mod_abs(sfp_mod_abs),
    .sfp_los(sfp_los), .sfp_tx_fault(sfp_tx_fault), .pcs_sync(pcs_sync),
    .sfp_tx_disable(sfp_tx_disable), .pcs_reset(pcs_reset), .link_up(link_up), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state by its status code, cycles spent in the state, low-LOS run, retries.
  // Pins reach the decision logic two edges late, so a two-deep history is kept.
  int m_st = 0, m_dwell = 0, m_low = 0, m_retry = 0;
  logic [3:0] h1 = '0, h2 = '0;

  always @(posedge clk or negedge reset) begin
    int nx;
    bit inc, rs, pll, abs, los, flt;
    if (!reset) begin
      m_st = 0; m_dwell = 0; m_low = 0; m_retry = 0; h1 = '0; h2 = '0;
    end else begin
      {pll, abs, los, flt} = h2;
      nx = m_st; inc = 0; rs = 0;
      if (!pll || abs) nx = 0;
      else if (flt && (m_st == 2 || m_st == 3 || m_st == 4)) begin nx = 15; inc = 1; end
      else if (m_st == 0) nx = 1;
      else if (m_st == 1) begin if (m_dwell + 1 == HOLD) nx = 2; end
      else if (m_st == 2) begin
        if (los) m_low = 0;
        else if (m_low + 1 == DEB) nx = 3;
        else m_low++;
      end
      else if (m_st == 3) begin
        if (pcs_sync) nx = 4;
        else if (m_dwell + 1 == TMO) begin nx = 1; inc = 1; end
      end
      else if (m_st == 4) begin if (!pcs_sync || los) begin nx = 1; inc = 1; end end
      else if (m_st == 15 && m_dwell + 1 == HOLD) begin if (flt) rs = 1; else nx = 0; end
      if (nx != m_st) begin m_dwell = 0; m_low = 0; end
      else if (rs) m_dwell = 0;
      else m_dwell++;
      m_st = nx;
      if (inc && m_retry < 15) m_retry++;
      h2 = h1;
      h1 = {pll_locked, sfp_mod_abs, sfp_los, sfp_tx_fault};
    end
  end

  always @(negedge clk)
    if (reset) begin
      chk("status", status, {m_st[3:0], m_retry[3:0]});
      chk("link_up", link_up, m_st == 4);
      chk("tx_disable", sfp_tx_disable, m_st == 0 || m_st == 1 || m_st == 15);
      chk("pcs_reset", pcs_reset, m_st == 0 || m_st == 1 || m_st == 15);
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_change(input string name, input int exp_n, input logic [7:0] exp_st);
    logic [7:0] from;
    int n;
    from = status;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (status == from && n < 2000);
    chk({name, " cycles"}, n, exp_n);
    chk({name, " status"}, status, exp_st);
  endtask

  initial begin
    int r;
    repeat (3) step();
    chk("rst status", status, 8'h00);
    chk("rst tx_disable", sfp_tx_disable, 1'b1);
    chk("rst pcs_reset", pcs_reset, 1'b1);
    chk("rst link_up", link_up, 1'b0);
    reset = 1'b1;
    repeat (3) step();
    chk("idle waits for lock", status, 8'h00);
    // Bring-up
    pll_locked = 1'b1; sfp_mod_abs = 1'b0; sfp_los = 1'b0;
    wait_change("idle->reset", 3, 8'h10);
    wait_change("reset hold", HOLD, 8'h20);
    chk("enable tx_disable", sfp_tx_disable, 1'b0);
    wait_change("los debounce", DEB, 8'h30);
    pcs_sync = 1'b1;
    wait_change("sync->link", 1, 8'h40);
    chk("link link_up", link_up, 1'b1);
    chk("link tx_disable", sfp_tx_disable, 1'b0);
    // TX fault in LINK, held 10 cycles past FAULT entry
    sfp_tx_fault = 1'b1;
    wait_change("link->fault", 3, 8'hF1);
    chk("fault tx_disable", sfp_tx_disable, 1'b1);
    pcs_sync = 1'b0;
    repeat (9) step();
    chk("fault held", status, 8'hF1);
    step();
    sfp_tx_fault = 1'b0;
    wait_change("fault->idle", 6, 8'h01);
    wait_change("idle->reset 2", 1, 8'h11);
    wait_change("reset hold 2", HOLD, 8'h21);
    // LOS glitch seen by the debounce at count 6
    repeat (4) step();
    sfp_los = 1'b1;
    step();
    sfp_los = 1'b0;
    wait_change("los glitch", 10, 8'h31);
    // Module removal together with TX fault in SYNC
    sfp_mod_abs = 1'b1; sfp_tx_fault = 1'b1;
    wait_change("removal", 3, 8'h01);
    chk("removal pcs_reset", pcs_reset, 1'b1);
    sfp_mod_abs = 1'b0; sfp_tx_fault = 1'b0;
    wait_change("reinsert", 3, 8'h11);
    wait_change("reset hold 3", HOLD, 8'h21);
    wait_change("los debounce 3", DEB, 8'h31);
    pcs_sync = 1'b1;
    wait_change("sync->link 3", 1, 8'h41);
    // Asynchronous reset in LINK
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async link_up", link_up, 1'b0);
    chk("async tx_disable", sfp_tx_disable, 1'b1);
    chk("async pcs_reset", pcs_reset, 1'b1);
    chk("async status", status, 8'h00);
    pcs_sync = 1'b0;
    step(); step();
    reset = 1'b1;
    wait_change("post-reset idle->reset", 3, 8'h10);
    wait_change("post-reset hold", HOLD, 8'h20);
    wait_change("post-reset debounce", DEB, 8'h30);
    // Repeated sync timeouts saturate the retry count
    r = 0;
    for (int i = 0; i < 20; i++) begin
      r = (r < 15) ? r + 1 : 15;
      wait_change("timeout", TMO, {4'h1, 4'(r)});
      wait_change("timeout hold", HOLD, {4'h2, 4'(r)});
      wait_change("timeout debounce", DEB, {4'h3, 4'(r)});
    end
    chk("retry saturated", status, 8'h3F);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
